// File: rtl/data_split_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_split_pkg
//  Purpose  : Shared state encoding, data width and frame-size derivation
//             for the combined-stream to paired-stream splitter.
//  Revision : 1.0
// ============================================================================
package data_split_pkg;

  // Sample width of both the combined input and the paired outputs.
  localparam int c_data_w       = 16;
  // Default index width parameter; half-frame length is 2^(BITWIDTH+2).
  localparam int c_def_bitwidth = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } split_state_t;

  // Half-frame length implied by a given BITWIDTH.
  function automatic int fft_point(input int bw);
    return 1 << (bw + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/split_ram_sdp.sv
`default_nettype none
// ============================================================================
//  Module   : split_ram_sdp
//  Purpose  : Simple dual-port RAM holding the first half of a frame;
//             one write port, one registered read port, no read reset.
//  Revision : 1.0
// ============================================================================
module split_ram_sdp #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Write port: store first-half samples.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle registered read, held when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_split_rl.sv
`default_nettype none
// ============================================================================
//  Module   : data_split_rl
//  Purpose  : Splits a combined frame (first half, then second half) into
//             aligned sample pairs; buffers the first half, then emits
//             {buffered k, live k} two cycles after each second-half sample.
//  Revision : 1.0
// ============================================================================
module data_split_rl
  import data_split_pkg::*;
#(
  parameter int BITWIDTH  = c_def_bitwidth,
  parameter int FFT_POINT = fft_point(c_def_bitwidth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_in,
  input  logic [BITWIDTH+2:0]   cnt_in,
  input  logic [c_data_w-1:0]   para_in,
  output logic                  en_out,
  output logic [BITWIDTH+1:0]   cnt_out,
  output logic [c_data_w-1:0]   para_out0,
  output logic [c_data_w-1:0]   para_out1,
  output logic                  last_out,
  output logic                  frame_err
);

  localparam int              c_aw   = BITWIDTH + 2;
  localparam logic [c_aw-1:0] c_last = c_aw'(FFT_POINT - 1);
  localparam logic [c_aw-1:0] c_one  = c_aw'(1);

  split_state_t          r_state, w_state_nxt;
  logic [c_aw-1:0]       r_idx, w_idx_nxt;
  logic                  w_match, w_zero, w_we, w_pair, w_err;
  logic                  r_s1_valid, r_s1_last;
  logic [c_aw-1:0]       r_s1_cnt;
  logic [c_data_w-1:0]   r_s1_data;
  logic [c_data_w-1:0]   w_rd_data;

  // The expected index is {half, k}; in IDLE this is 0, so a start sample
  // is simply the match case there.
  assign w_match = (cnt_in == {r_state == DRAIN, r_idx});
  assign w_zero  = (cnt_in == '0);

  // State and expected-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic, buffer write/read strobes and sequence-error detect.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_pair      = 1'b0;
    w_err       = 1'b0;
    if (en_in) begin
      case (r_state)
        IDLE: begin
          if (w_zero) begin
            w_we        = 1'b1;
            w_state_nxt = FILL;
            w_idx_nxt   = c_one;
          end
        end
        FILL, DRAIN: begin
          if (w_match) begin
            w_we      = (r_state == FILL);
            w_pair    = (r_state == DRAIN);
            w_idx_nxt = r_idx + c_one;
            if (r_idx == c_last) begin
              w_state_nxt = (r_state == FILL) ? DRAIN : IDLE;
            end
          end else begin
            w_err = 1'b1;
            if (w_zero) begin
              // Out-of-sequence frame start: treat it as a fresh frame.
              w_we        = 1'b1;
              w_state_nxt = FILL;
              w_idx_nxt   = c_one;
            end else begin
              w_state_nxt = IDLE;
              w_idx_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Write and read addresses are both the low bits of the incoming index.
  split_ram_sdp #(
    .DEPTH (FFT_POINT),
    .AW    (c_aw),
    .DW    (c_data_w)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_we),
    .wr_addr (cnt_in[c_aw-1:0]),
    .wr_data (para_in),
    .rd_en   (w_pair),
    .rd_addr (cnt_in[c_aw-1:0]),
    .rd_data (w_rd_data)
  );

  // First pipeline stage: align live sample with the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= w_pair;
    r_s1_data <= para_in;
    r_s1_cnt  <= cnt_in[c_aw-1:0];
    r_s1_last <= (r_idx == c_last);
  end

  // Registered outputs; everything is forced to zero when no pair is valid.
  always_ff @(posedge clk) begin
    if (rst || !r_s1_valid) begin
      en_out    <= 1'b0;
      cnt_out   <= '0;
      para_out0 <= '0;
      para_out1 <= '0;
      last_out  <= 1'b0;
    end else begin
      en_out    <= 1'b1;
      cnt_out   <= r_s1_cnt;
      para_out0 <= w_rd_data;
      para_out1 <= r_s1_data;
      last_out  <= r_s1_last;
    end
  end

  // Sequence-error pulse, one cycle after the offending sample.
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= w_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_split_rl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_split_rl
//  Purpose  : Self-checking bench for data_split_rl: per-cycle comparison
//             against a frame-level reference model, plus per-scenario
//             pair / error / last counts from a vector table.
//  Revision : 1.0
// ============================================================================
module tb_data_split_rl;

  localparam int BW = 7;
  localparam int FP = 512;
  localparam int CW = BW + 3;

  localparam int K_CLEAN = 0;
  localparam int K_JUMP  = 1;
  localparam int K_Z700  = 2;
  localparam int K_R800  = 3;
  localparam int K_JUNK  = 4;
  localparam int K_B2B   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_in;
  logic [CW-1:0] cnt_in;
  logic [15:0]   para_in;
  logic          en_out;
  logic [BW+1:0] cnt_out;
  logic [15:0]   para_out0;
  logic [15:0]   para_out1;
  logic          last_out;
  logic          frame_err;

  always #5 clk = ~clk;

  data_split_rl #(.BITWIDTH(BW), .FFT_POINT(FP)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .cnt_in    (cnt_in),
    .para_in   (para_in),
    .en_out    (en_out),
    .cnt_out   (cnt_out),
    .para_out0 (para_out0),
    .para_out1 (para_out1),
    .last_out  (last_out),
    .frame_err (frame_err)
  );

  typedef struct {
    bit          en;
    int          cnt;
    logic [15:0] p0;
    logic [15:0] p1;
    bit          last;
  } pair_t;

  typedef struct {
    string name;
    int    kind;
    bit    gap;
    bit    rnd;
    int    exp_pairs;
    int    exp_errs;
    int    exp_lasts;
  } vec_t;

  // Reference model state: the expected output of each future cycle.
  pair_t       pend [int];
  bit          perr [int];
  int          cyc;
  bit          m_active;
  int          m_exp;
  logic [15:0] mbuf [FP];

  int n_cmp, n_bad;
  int obs_pairs, obs_errs, obs_lasts;

  task automatic check_cycle();
    pair_t e;
    bit    ee;
    e  = '{en: 1'b0, cnt: 0, p0: 16'h0, p1: 16'h0, last: 1'b0};
    ee = 1'b0;
    if (pend.exists(cyc)) begin e = pend[cyc]; pend.delete(cyc); end
    if (perr.exists(cyc)) begin ee = 1'b1; perr.delete(cyc); end
    n_cmp++;
    if (en_out !== e.en || int'(cnt_out) != e.cnt || para_out0 !== e.p0 ||
        para_out1 !== e.p1 || last_out !== e.last || frame_err !== ee) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL cycle_out cyc=%0d got en=%0b cnt=%0d p0=%h p1=%h last=%0b err=%0b want en=%0b cnt=%0d p0=%h p1=%h last=%0b err=%0b",
                 cyc, en_out, cnt_out, para_out0, para_out1, last_out, frame_err,
                 e.en, e.cnt, e.p0, e.p1, e.last, ee);
    end
    if (en_out)             obs_pairs++;
    if (frame_err)          obs_errs++;
    if (en_out && last_out) obs_lasts++;
  endtask

  // Frame-level behaviour: first half is stored, second half pairs with it.
  task automatic model();
    int c;
    if (rst) begin
      m_active = 1'b0;
      m_exp    = 0;
      pend.delete();
      perr.delete();
    end else if (en_in) begin
      c = int'(cnt_in);
      if (!m_active) begin
        if (c == 0) begin mbuf[0] = para_in; m_active = 1'b1; m_exp = 1; end
      end else if (c == m_exp) begin
        if (c < FP) mbuf[c] = para_in;
        else pend[cyc + 2] = '{en: 1'b1, cnt: c - FP, p0: mbuf[c - FP],
                               p1: para_in, last: (c - FP == FP - 1)};
        m_exp++;
        if (m_exp == 2 * FP) begin m_active = 1'b0; m_exp = 0; end
      end else begin
        perr[cyc + 1] = 1'b1;
        if (c == 0) begin mbuf[0] = para_in; m_exp = 1; end
        else begin m_active = 1'b0; m_exp = 0; end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic send(input bit e, input int c, input logic [15:0] d);
    en_in   = e;
    cnt_in  = CW'(c);
    para_in = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, int'($urandom_range(0, 1023)), 16'($urandom));
  endtask

  task automatic run_range(input int lo, input int hi, input bit gap, input bit rnd);
    for (int c = lo; c < hi; c++) begin
      send(1'b1, c, rnd ? 16'($urandom) : 16'(c));
      if (gap)      idle(1);
      else if (rnd) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  vec_t tbl [9];

  initial begin
    int sp, se, sl;
    tbl[0] = '{"clean",       K_CLEAN, 1'b0, 1'b0,  512, 0, 1};
    tbl[1] = '{"gap_toggle",  K_CLEAN, 1'b1, 1'b0,  512, 0, 1};
    tbl[2] = '{"jump_300",    K_JUMP,  1'b0, 1'b0,    0, 1, 0};
    tbl[3] = '{"rand_clean",  K_CLEAN, 1'b0, 1'b1,  512, 0, 1};
    tbl[4] = '{"zero_at_700", K_Z700,  1'b0, 1'b0,  700, 1, 1};
    tbl[5] = '{"rst_at_800",  K_R800,  1'b0, 1'b0,  287, 0, 0};
    tbl[6] = '{"after_rst",   K_CLEAN, 1'b0, 1'b1,  512, 0, 1};
    tbl[7] = '{"idle_junk",   K_JUNK,  1'b0, 1'b0,    0, 0, 0};
    tbl[8] = '{"back2back",   K_B2B,   1'b0, 1'b0, 1024, 0, 2};

    n_cmp = 0; n_bad = 0; obs_pairs = 0; obs_errs = 0; obs_lasts = 0;
    m_active = 1'b0; m_exp = 0;
    rst = 1'b1; en_in = 1'b0; cnt_in = '0; para_in = '0;
    @(posedge clk);
    #1;
    cyc = 0;
    repeat (3) tick();
    chk("reset_en_out",    int'(en_out),    0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_para_out1", int'(para_out1), 0);
    rst = 1'b0;
    idle(4);

    for (int v = 0; v < 9; v++) begin
      sp = obs_pairs; se = obs_errs; sl = obs_lasts;
      case (tbl[v].kind)
        K_CLEAN: run_range(0, 2 * FP, tbl[v].gap, tbl[v].rnd);
        K_JUMP: begin
          run_range(0, 301, 1'b0, 1'b0);
          run_range(302, 2 * FP, 1'b0, 1'b0);
        end
        K_Z700: begin
          run_range(0, 700, 1'b0, 1'b0);
          run_range(0, 2 * FP, 1'b0, 1'b1);
        end
        K_R800: begin
          run_range(0, 800, 1'b0, 1'b0);
          rst = 1'b1;
          send(1'b1, 800, 16'd800);
          rst = 1'b0;
          run_range(801, 2 * FP, 1'b0, 1'b0);
        end
        K_JUNK:  for (int i = 0; i < 50; i++)
                   send(1'b1, int'($urandom_range(1, 1023)), 16'($urandom));
        default: begin
          run_range(0, 2 * FP, 1'b0, 1'b0);
          run_range(0, 2 * FP, 1'b0, 1'b1);
        end
      endcase
      idle(6);
      chk({tbl[v].name, "_pairs"}, obs_pairs - sp, tbl[v].exp_pairs);
      chk({tbl[v].name, "_errs"},  obs_errs  - se, tbl[v].exp_errs);
      chk({tbl[v].name, "_lasts"}, obs_lasts - sl, tbl[v].exp_lasts);
    end

    // Error in DRAIN: pairs already in flight must still come out.
    sp = obs_pairs; se = obs_errs;
    run_range(0, 600, 1'b0, 1'b0);
    send(1'b1, 5, 16'h1234);
    idle(6);
    chk("drain_err_pairs", obs_pairs - sp, 88);
    chk("drain_err_errs",  obs_errs  - se, 1);

    // Recovery frame after the DRAIN error.
    sp = obs_pairs; se = obs_errs;
    run_range(0, 2 * FP, 1'b0, 1'b1);
    idle(6);
    chk("recover_pairs", obs_pairs - sp, 512);
    chk("recover_errs",  obs_errs  - se, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_split_rl.md
DATA_SPLIT_RL -- requirements
Module: data_split_rl

Interface
REQ-001 SHALL have parameter BITWIDTH, default 7, which sets index widths.
REQ-002 SHALL have parameter FFT_POINT, default 512, the half-frame length; FFT_POINT SHALL equal 2^(BITWIDTH+2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port en_in, input, 1 bit, which qualifies each input sample.
REQ-006 SHALL have port cnt_in, input, BITWIDTH+3 bits, the sample index within a combined frame (0..2*FFT_POINT-1).
REQ-007 SHALL have port para_in, input, 16 bits, the combined-stream sample.
REQ-008 SHALL have port en_out, output, 1 bit, which qualifies each output pair.
REQ-009 SHALL have port cnt_out, output, BITWIDTH+2 bits, the pair index (0..FFT_POINT-1).
REQ-010 SHALL have ports para_out0 and para_out1, outputs, 16 bits each, carrying the first-half and second-half samples.
REQ-011 SHALL have port last_out, output, 1 bit, high with the pair where cnt_out = FFT_POINT-1.
REQ-012 SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a sequence error.

Function
REQ-013 SHALL implement FSM states IDLE, FILL and DRAIN, leaving IDLE on any accepted sample with cnt_in = 0.
REQ-014 IDLE: SHALL ignore samples with cnt_in != 0, and SHALL NOT raise frame_err for them.
REQ-015 FILL: SHALL write each accepted sample with cnt_in = expected index k (0..FFT_POINT-1) to buffer address k, and after k = FFT_POINT-1 SHALL move to DRAIN.
REQ-016 DRAIN: for accepted cnt_in = FFT_POINT+k, SHALL read buffer address k, emitting para_out0 = buffered sample k, para_out1 = para_in, cnt_out = k and en_out = 1 exactly 2 cycles later; after k = FFT_POINT-1 SHALL return to IDLE.
REQ-017 en_in low mid-frame SHALL hold state and expected index (gaps allowed); outputs for the gap cycles SHALL be en_out = 0.
REQ-018 Mismatch (accepted cnt_in != expected, in FILL or DRAIN) SHALL pulse frame_err 1 cycle later, abandon the frame, and go to IDLE; if the offending cnt_in = 0, it SHALL instead restart FILL with that sample written.
REQ-019 While en_out = 0, para_out0, para_out1, cnt_out and last_out SHALL be 0.
REQ-020 A pair already in the 2-cycle pipeline SHALL still be emitted when a later error occurs.
REQ-021 Back-to-back frames (cnt_in = 0 on the cycle after 2*FFT_POINT-1) SHALL run at full rate without lost samples.

Reset
REQ-022 rst SHALL clear en_out, cnt_out, para_out0, para_out1, last_out and frame_err to 0 on the next clock edge.
REQ-023 rst SHALL force the FSM to IDLE and the expected index to 0, and SHALL flush the pipeline.
REQ-024 Buffer contents SHALL need no reset.
REQ-025 rst asserted mid-frame SHALL suppress all remaining output of that frame.

Structure
REQ-026 State encodings and FFT_POINT/width derivations SHALL live in a shared include, data_split_pkg.
REQ-027 The buffer SHALL be a single sub-module, split_ram_sdp: simple dual-port, FFT_POINT x 16, 1-cycle registered read, no read reset.
REQ-028 All outputs SHALL be registered.

Verification
REQ-029 Frame with para_in = cnt_in (0..1023), continuous -> 512 pairs; pair k has para_out0 = k, para_out1 = 512+k, first en_out 2 cycles after cnt_in = 512, last_out with k = 511.
REQ-030 Same frame with en_in toggling 1/0 -> identical pair values, with en_out spaced by the gaps.
REQ-031 cnt_in jumps 300 -> 302 in FILL -> frame_err pulses once, no en_out for that frame, next clean frame is correct.
REQ-032 cnt_in = 0 arrives at expected 700 -> frame_err pulses, new frame fills from that sample, its pairs are correct.
REQ-033 rst for 1 cycle at cnt_in = 800 -> all outputs 0 from the next edge, no further pairs, later frame is correct.
REQ-034 Two back-to-back frames -> 1024 pairs, no gap other than the FILL phase, no frame_err.
